// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit-side FIFO.
package uart_pkg;
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_BUSY} state_t;
   localparam int NB_DATA_DEF = 8;
   localparam int NB_DROP_CNT = 8;
endpackage

// File: rtl/tx_fifo_storage.sv
// tx_fifo_storage: circular byte store with wrapping pointers and an occupancy count.
module tx_fifo_storage #(
   parameter int NB_DATA = 8,
   parameter int NB_ADDR = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [NB_DATA-1:0] i_data,
   output logic [NB_DATA-1:0] o_head,
   output logic               o_full,
   output logic               o_empty,
   output logic [NB_ADDR:0]   o_count
);
   localparam int DEPTH = 2**NB_ADDR;
   logic [NB_DATA-1:0] mem_q [DEPTH];
   logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NB_ADDR:0]   count_q, count_d;
   always_comb begin
      wr_ptr_d = i_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = i_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + (NB_ADDR+1)'(i_push) - (NB_ADDR+1)'(i_pop);
   end
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
   // Contents need no reset: the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (i_push) mem_q[wr_ptr_q] <= i_data;
   end
   assign o_head  = mem_q[rd_ptr_q];
   assign o_full  = count_q == (NB_ADDR+1)'(DEPTH);
   assign o_empty = count_q == '0;
   assign o_count = count_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers ALU result bytes and hands them one at a time to the UART transmitter.
// Define UART_TX_FIFO_DROP_CNT_EN to add a saturating 8-bit dropped-write counter output.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = 4
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NB_DATA-1:0]     i_data,
   input  logic                   i_valid,
   input  logic                   i_tx_ready,
   output logic [NB_DATA-1:0]     o_data,
   output logic                   o_valid,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [NB_ADDR:0]       o_count,
`ifdef UART_TX_FIFO_DROP_CNT_EN
   output logic                   o_overflow,
   output logic [NB_DROP_CNT-1:0] o_drop_count
`else
   output logic                   o_overflow
`endif
);
   state_t             state_q, state_d;
   logic [NB_DATA-1:0] data_q, data_d, head;
   logic               overflow_q, overflow_d, push, pop;
   tx_fifo_storage #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_storage (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (push),
      .i_pop   (pop),
      .i_data  (i_data),
      .o_head  (head),
      .o_full  (o_full),
      .o_empty (o_empty),
      .o_count (o_count)
   );
   // Full is the registered flag, so a write colliding with a pop while full is still dropped.
   always_comb begin
      push       = i_valid && !o_full;
      overflow_d = i_valid && o_full;
      pop        = 1'b0;
      state_d    = state_q;
      data_d     = data_q;
      case (state_q)
         S_IDLE: if (!o_empty) begin
            pop     = 1'b1;
            data_d  = head;
            state_d = S_SEND;
         end
         S_SEND:      if (i_tx_ready) state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: if (!i_tx_ready) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= S_IDLE;
         data_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         overflow_q <= overflow_d;
      end
   end
   // Valid is decoded from the state register so reset clears it without a clock.
   assign o_valid    = state_q == S_SEND;
   assign o_data     = data_q;
   assign o_overflow = overflow_q;
`ifdef UART_TX_FIFO_DROP_CNT_EN
   logic [NB_DROP_CNT-1:0] drop_cnt_q, drop_cnt_d;
   always_comb drop_cnt_d = (overflow_d && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) drop_cnt_q <= '0;
      else          drop_cnt_q <= drop_cnt_d;
   end
   assign o_drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; bytes are queued when written and matched at each transmitter handoff.
module tb_uart_tx_fifo;
   logic       i_clk = 1'b0;
   logic       i_reset = 1'b0;
   logic [7:0] i_data = '0;
   logic       i_valid = 1'b0;
   logic       i_tx_ready = 1'b0;
   logic [7:0] o_data;
   logic       o_valid, o_full, o_empty, o_overflow;
   logic [4:0] o_count;
`ifdef UART_TX_FIFO_DROP_CNT_EN
   logic [7:0] o_drop_count;
`endif
   int         errors = 0;
   int         checks = 0;
   int         xfers = 0;
   logic [7:0] sb[$];
   logic [7:0] next_byte = 8'h40;

   uart_tx_fifo dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_data     (i_data),
      .i_valid    (i_valid),
      .i_tx_ready (i_tx_ready),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_full     (o_full),
      .o_empty    (o_empty),
      .o_count    (o_count),
`ifdef UART_TX_FIFO_DROP_CNT_EN
      .o_overflow (o_overflow),
      .o_drop_count(o_drop_count)
`else
      .o_overflow (o_overflow)
`endif
   );

   always #5 i_clk = ~i_clk;

   // Inputs change 1ns after a rising edge, so at the falling edge they equal what the next edge sees.
   always @(negedge i_clk) begin
      if (i_reset && o_valid && i_tx_ready) begin
         logic [7:0] exp;
         xfers++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL handoff_unexpected: got %02h, required no transfer", o_data);
         end else begin
            exp = sb.pop_front();
            if (o_data !== exp) begin
               errors++;
               $display("FAIL handoff_data: got %02h, required %02h", o_data, exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_traffic(input int n, input int busy_len, input int budget);
      int   written = 0;
      int   busy = 0;
      int   cyc = 0;
      logic hv;
      i_tx_ready = 1'b1;
      while ((written < n || sb.size() > 0) && cyc < budget) begin
         if (written < n && !o_full && $urandom_range(0, 2) == 0) begin
            i_data = next_byte;
            i_valid = 1'b1;
            sb.push_back(next_byte);
            next_byte++;
            written++;
         end else i_valid = 1'b0;
         hv = o_valid && i_tx_ready;
         tick();
         cyc++;
         if (hv) begin
            busy = busy_len;
            i_tx_ready = 1'b0;
         end else if (busy > 0) begin
            busy--;
            if (busy == 0) i_tx_ready = 1'b1;
         end
      end
      i_valid = 1'b0;
      checks++;
      if (cyc >= budget) begin
         errors++;
         $display("FAIL traffic_timeout: %0d bytes still pending after %0d cycles, required 0", sb.size(), cyc);
         sb.delete();
      end
      while (busy > 0) begin
         tick();
         busy--;
      end
      i_tx_ready = 1'b1;
      tick();
      checks++;
      if (o_empty !== 1'b1 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL traffic_end: empty=%b valid=%b, required empty=1 valid=0", o_empty, o_valid);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++; if (o_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b, required 0", o_valid); end
      checks++; if (o_data !== 8'h00)  begin errors++; $display("FAIL reset_data: got %02h, required 00", o_data); end
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", o_overflow); end
      checks++; if (o_count !== 5'd0)  begin errors++; $display("FAIL reset_count: got %0d, required 0", o_count); end
      checks++; if (o_empty !== 1'b1)  begin errors++; $display("FAIL reset_empty: got %b, required 1", o_empty); end
      checks++; if (o_full !== 1'b0)   begin errors++; $display("FAIL reset_full: got %b, required 0", o_full); end
`ifdef UART_TX_FIFO_DROP_CNT_EN
      checks++; if (o_drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count: got %0d, required 0", o_drop_count); end
`endif
      i_reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int x0;
      x0 = xfers;
      i_tx_ready = 1'b1;
      i_data = 8'hA5;
      i_valid = 1'b1;
      sb.push_back(8'hA5);
      tick();
      i_valid = 1'b0;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b, required 0", o_valid); end
      tick();
      checks++; if (o_valid !== 1'b1 || o_data !== 8'hA5) begin errors++; $display("FAIL single_latency: valid=%b data=%02h, required 1 a5", o_valid, o_data); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL single_wait_busy: cycle %0d valid=%b, required 0", i, o_valid); end
      end
      i_tx_ready = 1'b0;
      tick();
      i_tx_ready = 1'b1;
      tick();
      tick();
      checks++; if (xfers - x0 !== 1 || o_valid !== 1'b0 || o_empty !== 1'b1) begin
         errors++; $display("FAIL single_one_transfer: transfers=%0d valid=%b empty=%b, required 1 0 1", xfers - x0, o_valid, o_empty);
      end
   endtask

   task automatic test_burst_overflow();
      i_tx_ready = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         i_data = 8'(i);
         i_valid = 1'b1;
         sb.push_back(8'(i));
         tick();
      end
      i_valid = 1'b0;
      checks++; if (o_count !== 5'd15 || o_full !== 1'b0) begin errors++; $display("FAIL burst_count: count=%0d full=%b, required 15 0", o_count, o_full); end
      checks++; if (o_valid !== 1'b1 || o_data !== 8'h00) begin errors++; $display("FAIL burst_head: valid=%b data=%02h, required 1 00", o_valid, o_data); end
      i_data = 8'h10;
      i_valid = 1'b1;
      sb.push_back(8'h10);
      tick();
      i_valid = 1'b0;
      checks++; if (o_full !== 1'b1 || o_count !== 5'd16) begin errors++; $display("FAIL burst_full: full=%b count=%0d, required 1 16", o_full, o_count); end
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL burst_no_overflow: got %b, required 0", o_overflow); end
      i_data = 8'hEE;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      checks++; if (o_overflow !== 1'b1 || o_count !== 5'd16) begin errors++; $display("FAIL overflow_pulse: overflow=%b count=%0d, required 1 16", o_overflow, o_count); end
      tick();
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL overflow_one_cycle: got %b, required 0", o_overflow); end
`ifdef UART_TX_FIFO_DROP_CNT_EN
      checks++; if (o_drop_count !== 8'd1) begin errors++; $display("FAIL drop_count: got %0d, required 1", o_drop_count); end
`endif
      run_traffic(0, 10, 1000);
   endtask

   task automatic test_drain_wrap();
      run_traffic(40, 10, 5000);
   endtask

   task automatic test_push_pop();
      i_tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         i_data = 8'h80 + 8'(i);
         i_valid = 1'b1;
         sb.push_back(8'h80 + 8'(i));
         tick();
      end
      i_valid = 1'b0;
      tick();
      i_tx_ready = 1'b1;
      tick();
      i_tx_ready = 1'b0;
      tick();
      checks++; if (o_count !== 5'd5 || o_valid !== 1'b0) begin errors++; $display("FAIL pushpop_setup: count=%0d valid=%b, required 5 0", o_count, o_valid); end
      i_data = 8'h86;
      i_valid = 1'b1;
      sb.push_back(8'h86);
      tick();
      i_valid = 1'b0;
      checks++; if (o_count !== 5'd5) begin errors++; $display("FAIL pushpop_count: got %0d, required 5", o_count); end
      checks++; if (o_valid !== 1'b1 || o_data !== 8'h81) begin errors++; $display("FAIL pushpop_head: valid=%b data=%02h, required 1 81", o_valid, o_data); end
      run_traffic(0, 10, 1000);
   endtask

   task automatic test_reset_mid();
      int x0;
      i_tx_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         i_data = 8'hC0 + 8'(i);
         i_valid = 1'b1;
         sb.push_back(8'hC0 + 8'(i));
         tick();
      end
      i_valid = 1'b0;
      checks++; if (o_count !== 5'd3 || o_valid !== 1'b1) begin errors++; $display("FAIL midreset_setup: count=%0d valid=%b, required 3 1", o_count, o_valid); end
      #1;
      i_reset = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_async_valid: got %b, required 0", o_valid); end
      sb.delete();
      tick();
      tick();
      i_reset = 1'b1;
      tick();
      checks++; if (o_empty !== 1'b1 || o_count !== 5'd0) begin errors++; $display("FAIL midreset_cleared: empty=%b count=%0d, required 1 0", o_empty, o_count); end
      x0 = xfers;
      for (int i = 0; i < 20; i++) begin
         i_tx_ready = (i % 4) < 2;
         tick();
      end
      checks++; if (xfers !== x0 || o_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale: transfers=%0d valid=%b, required 0 0", xfers - x0, o_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst_overflow();
      test_drain_wrap();
      test_push_pop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Output buffer between the ALU interface stage and the UART transmitter.
- Accepts one-cycle result strobes, stores up to 2**NB_ADDR bytes, and hands them to the transmitter one at a time.
- Prevents results from being lost while the transmitter is busy shifting a frame at the baud tick rate.

Parameters:
- NB_DATA, 8, data byte width.
- NB_ADDR, 4, pointer width; depth = 2**NB_ADDR (16).

Ports:
- i_clk  input  1  system clock (PLL output domain).
- i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_data  input  NB_DATA  result byte from the ALU interface.
- i_valid  input  1  one-cycle write strobe qualifying i_data.
- i_tx_ready  input  1  transmitter idle flag; high while able to accept a byte.
- o_data  output  NB_DATA  byte presented to the transmitter.
- o_valid  output  1  o_data valid toward the transmitter.
- o_full  output  1  count == 2**NB_ADDR.
- o_empty  output  1  count == 0.
- o_count  output  NB_ADDR+1  number of stored bytes, excluding the byte held in o_data.
- o_overflow  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (i_reset low, asynchronous):
  - o_valid=0, o_data=0, o_overflow=0, o_count=0, o_empty=1, o_full=0.
  - wr_ptr=rd_ptr=0; state=S_IDLE.
  - Stored bytes are discarded.
  - Reset mid-transfer drops o_valid immediately, with no wait for the clock edge.
- Write:
  - On a rising edge with i_valid=1 and o_full=0: mem[wr_ptr]<=i_data, wr_ptr wraps modulo depth, count+1.
  - i_valid=1 with o_full=1: byte dropped, pointers unchanged, o_overflow=1 next cycle for exactly one cycle.
  - Full is judged on registered count. A write in the same cycle as a pop while full is still dropped.
- Read FSM, states S_IDLE, S_SEND, S_WAIT_BUSY:
  - S_IDLE: if count>0, then o_data<=mem[rd_ptr], rd_ptr wraps, count-1, o_valid<=1, next S_SEND. Otherwise stay, o_valid=0.
  - S_SEND: o_valid=1, o_data stable. When i_tx_ready=1, o_valid<=0 and next S_WAIT_BUSY.
  - S_WAIT_BUSY: o_valid=0. Wait until i_tx_ready=0 (transmitter has started), then next S_IDLE. This blocks double-issue while the transmitter's ready lags the handoff.
- Latency: a byte written at edge N into an empty FIFO with FSM in S_IDLE shows o_valid=1 after edge N+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: the pointer after 2**NB_ADDR-1 is 0. Count is NB_ADDR+1 bits so full and empty are distinguishable.
- o_full, o_empty and o_count are registered/derived from the same count register, with no combinational path from i_valid.
- o_data changes only on the S_IDLE→S_SEND transition.

Optional Feature:
- Macro: UART_TX_FIFO_DROP_CNT_EN.
- Defined:
  - Adds output o_drop_count, 8 bits.
  - Increments on every dropped write and saturates at 255.
  - Cleared only by reset.
- Undefined: port absent. o_overflow pulse is the only drop indication.

Decomposition:
- Shared package uart_pkg:
  - FSM state typedef (S_IDLE, S_SEND, S_WAIT_BUSY).
  - NB_DATA default constant.
  - Drop-counter width constant (8).
- One sub-module, tx_fifo_storage:
  - Holds the memory array, wr/rd pointers and count.
  - Write/pop strobes in, head byte and flags out.
  - The FSM and handshake stay in uart_tx_fifo.

Test Plan:
- Single byte, reset released, i_tx_ready=1: write 0xA5 → o_valid high one edge later with o_data=0xA5. After handoff, o_valid stays low until i_tx_ready toggles low then high; exactly one transfer.
- Burst with transmitter busy: i_tx_ready=0, write 0x00..0x0F on consecutive cycles → count reaches 15 (one byte in o_data), o_full=0. A 17th write sets o_full.
- Overflow: with o_full=1, write 0xEE → o_overflow pulses one cycle, count stays 16, 0xEE never appears on o_data. With the macro defined, o_drop_count=1.
- Drain order across wrap: fill and drain 40 bytes in mixed push/pop traffic, emulating a transmitter that drops ready for 10 cycles per byte → output sequence equals input sequence, o_empty=1 at end.
- Simultaneous push/pop: count=5, write on the same edge as the S_IDLE pop → count stays 5.
- Reset mid-operation: assert i_reset low while in S_SEND with count=3 → o_valid falls asynchronously. After release: o_empty=1, o_count=0, no stale byte transmitted.
